pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_pc_reg.sv | 47 ++++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter fetch sequencer:
//   - seq_state_e : sequencer states (IDLE, FETCH, ISSUE, HALTED)
//   - PC_W_DEF    : default program counter / instruction address width
//   - INSTR_W_DEF : default instruction word width
//   - RESET_PC_DEF: default PC value loaded while rst_n is low
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int          PC_W_DEF     = 8;
    localparam int          INSTR_W_DEF  = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory read bus between the fetch sequencer and the memory.
//   imem_req   : read request (sequencer -> memory)
//   imem_addr  : read address (sequencer -> memory)
//   imem_ack   : read data valid this cycle (memory -> sequencer)
//   imem_rdata : read data (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
// Program counter register with an absolute load and a sequential increment.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   i_load         : load i_loadValue (takes precedence over i_inc)
//   i_loadValue    : absolute value to load
//   i_inc          : advance by one, modulo 2^PC_W
//   o_pc           : current program counter
//   o_wrap         : one-cycle pulse after an increment from all-ones
// ----------------------------------------------------------------------------
module pc_reg #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_loadValue,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc,
    output logic            o_wrap
);

    logic [PC_W-1:0] r_pc;
    logic            r_wrap;

    // Loads never raise the wrap flag, even when the target arithmetic
    // overflowed; only the plain +1 out of all-ones counts as a wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc   <= RESET_PC;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_pc <= i_loadValue;
            end else if (i_inc) begin
                r_pc   <= r_pc + PC_W'(1);
                r_wrap <= &r_pc;
            end
        end
    end

    assign o_pc   = r_pc;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Fetch controller owning the program counter. Requests the instruction at
// pc, holds it for the consumer, then advances pc by +1, jump or branch.
//   sysclk, rst_n        : clock, asynchronous active-low reset
//   start                : leave IDLE/HALTED and begin fetching
//   stall                : consumer not ready, hold the issued instruction
//   halt                 : stop after the current instruction
//   jump_en, jump_addr   : absolute redirect
//   branch_en, branch_off: relative redirect (two's-complement offset)
//   imem                 : instruction memory read bus (master side)
//   instr, instr_valid   : latched instruction presented to the consumer
//   pc                   : current program counter (also drives imem_addr)
//   halted               : sequencer is in HALTED
//   pc_wrap              : one-cycle pulse on a sequential wrap
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               halt,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_off,
    pc_sequencer_if.master     imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               pc_wrap
);

    seq_state_e         r_state;
    seq_state_e         w_nextState;
    logic [INSTR_W-1:0] r_instr;
    logic               r_imemReq;
    logic               r_instrValid;
    logic               r_halted;
    logic               w_load;
    logic [PC_W-1:0]    w_loadValue;
    logic               w_inc;
    logic               w_latch;
    logic [PC_W-1:0]    w_pc;
    logic               w_wrap;
    logic [PC_W-1:0]    w_branchTarget;

    // The offset is already PC_W wide, so sign extension to PC_W is the
    // identity and a plain modular add gives the relative target.
    assign w_branchTarget = w_pc + branch_off;

    // Next-state and PC control. Redirect inputs only matter on the cycle
    // ISSUE is left; a stalled ISSUE ignores them completely. Resuming from
    // HALTED steps past the instruction that was halted on.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadValue = jump_addr;
        w_inc       = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    w_latch     = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (halt) begin
                        w_nextState = HALTED;
                    end else if (jump_en) begin
                        w_load      = 1'b1;
                        w_loadValue = jump_addr;
                        w_nextState = FETCH;
                    end else if (branch_en) begin
                        w_load      = 1'b1;
                        w_loadValue = w_branchTarget;
                        w_nextState = FETCH;
                    end else begin
                        w_inc       = 1'b1;
                        w_nextState = FETCH;
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    w_inc       = 1'b1;
                    w_nextState = FETCH;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register plus registered status outputs. The status flags are
    // decoded from the next state so they line up with the state register
    // while still coming straight from flops; reset clears them at once,
    // which also withdraws any outstanding memory request.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_instr      <= '0;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_imemReq    <= (w_nextState == FETCH);
            r_instrValid <= (w_nextState == ISSUE);
            r_halted     <= (w_nextState == HALTED);
            if (w_latch) begin
                r_instr <= imem.imem_rdata;
            end
        end
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pcReg (
        .i_clk       (sysclk),
        .i_rst_n     (rst_n),
        .i_load      (w_load),
        .i_loadValue (w_loadValue),
        .i_inc       (w_inc),
        .o_pc        (w_pc),
        .o_wrap      (w_wrap)
    );

    assign imem.imem_req  = r_imemReq;
    assign imem.imem_addr = w_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_instrValid;
    assign pc             = w_pc;
    assign halted         = r_halted;
    assign pc_wrap        = w_wrap;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Scoreboard bench for pc_sequencer. The stimulus process plays both the
// instruction memory and the consumer, keeps its own program-flow model of
// where the next fetch must go, and queues the expected events. A separate
// monitor process pops and compares whenever the DUT starts a fetch,
// presents an instruction or enters HALTED.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        halt;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        branch_en;
    logic [7:0]  branch_off;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;
    logic        pc_wrap;

    pc_sequencer_if #(.PC_W(8), .INSTR_W(16)) imemBus ();

    pc_sequencer #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .imem        (imemBus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .pc_wrap     (pc_wrap)
    );

    always #5 sysclk = ~sysclk;

    typedef enum int {EV_FETCH = 0, EV_ISSUE = 1, EV_HALT = 2} evKind_e;

    typedef struct {
        evKind_e     kind;
        logic [7:0]  addr;
        logic        wrap;
        int          gap;
        logic [15:0] data;
    } expEvent_t;

    typedef struct {
        int         stalls;
        bit         doHalt;
        bit         doJump;
        bit         doBranch;
        logic [7:0] target;
        logic [7:0] offset;
    } decision_t;

    expEvent_t   expQ[$];
    decision_t   decQ[$];
    logic [15:0] dataQ[$];
    int          delayQ[$];

    int          vectors     = 0;
    int          miscompares = 0;
    int          issueSeen   = 0;

    logic [7:0]  modelPc;
    bit          memBusy;
    int          memDelay;
    int          instrDelay;
    bit          memHold;
    bit          haveDec;
    decision_t   curDec;
    int          stallLeft;
    int          stallsThis;
    bit          monOn;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic decision_t mkDec(input int stalls, input bit h, input bit j,
                                        input bit b, input logic [7:0] t,
                                        input logic [7:0] o);
        decision_t d;
        d.stalls   = stalls;
        d.doHalt   = h;
        d.doJump   = j;
        d.doBranch = b;
        d.target   = t;
        d.offset   = o;
        return d;
    endfunction

    function automatic decision_t randomDecision();
        decision_t d;
        d.stalls   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        d.doHalt   = ($urandom_range(0, 15) == 0);
        d.doJump   = ($urandom_range(0, 3) == 0);
        d.doBranch = ($urandom_range(0, 3) == 0);
        d.target   = 8'($urandom);
        d.offset   = 8'($urandom);
        return d;
    endfunction

    task automatic pushFetch(input logic [7:0] addr, input logic wrap, input int gap);
        expEvent_t e;
        e.kind = EV_FETCH;
        e.addr = addr;
        e.wrap = wrap;
        e.gap  = gap;
        e.data = '0;
        expQ.push_back(e);
    endtask

    // One clock of memory + consumer behaviour, driven on the falling edge.
    // Expected events are queued here from the bench's own view of program
    // flow: the consumer's decision defines where the next fetch must land.
    task automatic applyStimulus();
        expEvent_t   e;
        logic [15:0] d;
        logic        wrap;
        int          gap;
        @(negedge sysclk);
        if (imemBus.imem_req) begin
            if (!memBusy) begin
                memBusy = 1'b1;
                if (memHold && modelPc == 8'h33)
                    memDelay = 1 << 30;
                else if (delayQ.size() > 0)
                    memDelay = delayQ.pop_front();
                else
                    memDelay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                instrDelay = memDelay;
            end
            if (memDelay == 0) begin
                d = (dataQ.size() > 0) ? dataQ.pop_front() : 16'($urandom);
                imemBus.imem_ack   = 1'b1;
                imemBus.imem_rdata = d;
                e.kind = EV_ISSUE;
                e.addr = modelPc;
                e.wrap = 1'b0;
                e.gap  = -1;
                e.data = d;
                expQ.push_back(e);
                memBusy = 1'b0;
            end else begin
                memDelay--;
                imemBus.imem_ack   = 1'b0;
                imemBus.imem_rdata = 16'($urandom);
            end
        end else begin
            imemBus.imem_ack   = ($urandom_range(0, 5) == 0);
            imemBus.imem_rdata = 16'($urandom);
        end

        if (instr_valid) begin
            if (!haveDec) begin
                curDec     = (decQ.size() > 0) ? decQ.pop_front() : randomDecision();
                haveDec    = 1'b1;
                stallLeft  = curDec.stalls;
                stallsThis = 0;
            end
            halt       = curDec.doHalt;
            jump_en    = curDec.doJump;
            jump_addr  = curDec.target;
            branch_en  = curDec.doBranch;
            branch_off = curDec.offset;
            start      = ($urandom_range(0, 3) == 0);
            if (stallLeft > 0) begin
                stall = 1'b1;
                stallLeft--;
                stallsThis++;
            end else begin
                stall   = 1'b0;
                haveDec = 1'b0;
                gap     = 2 + instrDelay + stallsThis;
                if (curDec.doHalt) begin
                    e.kind = EV_HALT;
                    e.addr = modelPc;
                    e.wrap = 1'b0;
                    e.gap  = -1;
                    e.data = '0;
                    expQ.push_back(e);
                end else if (curDec.doJump) begin
                    modelPc = curDec.target;
                    pushFetch(modelPc, 1'b0, gap);
                end else if (curDec.doBranch) begin
                    modelPc = 8'((int'(modelPc) + int'($signed(curDec.offset)) + 256) % 256);
                    pushFetch(modelPc, 1'b0, gap);
                end else begin
                    wrap    = (modelPc == 8'hFF);
                    modelPc = 8'((int'(modelPc) + 1) % 256);
                    pushFetch(modelPc, wrap, gap);
                end
            end
        end else begin
            stall      = 1'($urandom);
            halt       = 1'($urandom);
            jump_en    = 1'($urandom);
            jump_addr  = 8'($urandom);
            branch_en  = 1'($urandom);
            branch_off = 8'($urandom);
            if (halted) begin
                if ($urandom_range(0, 2) == 0) begin
                    start   = 1'b1;
                    wrap    = (modelPc == 8'hFF);
                    modelPc = 8'((int'(modelPc) + 1) % 256);
                    pushFetch(modelPc, wrap, -1);
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    // Monitor: compares every DUT presentation against the head of the
    // expected-event queue, and checks hold/stability rules each cycle.
    logic        monPrevReq;
    logic        monPrevValid;
    logic        monPrevHalted;
    int          monCyc;
    int          monLastFetch;
    logic [15:0] monInstr;
    logic [7:0]  monPc;
    logic        monExpWrap;

    initial begin
        expEvent_t ev;
        monPrevReq    = 1'b0;
        monPrevValid  = 1'b0;
        monPrevHalted = 1'b0;
        monCyc        = 0;
        monLastFetch  = -1;
        monInstr      = 'x;
        monPc         = 'x;
        forever begin
            @(negedge sysclk);
            monCyc++;
            if (!rst_n || !monOn) begin
                monPrevReq    = 1'b0;
                monPrevValid  = 1'b0;
                monPrevHalted = 1'b0;
                monLastFetch  = -1;
                continue;
            end
            monExpWrap = 1'b0;
            checkOutput("imem_addr vs pc", imemBus.imem_addr, pc);

            if (imemBus.imem_req && !monPrevReq) begin
                checkOutput("fetch expected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    ev = expQ.pop_front();
                    checkOutput("fetch event kind", ev.kind, EV_FETCH);
                    if (ev.kind == EV_FETCH) begin
                        checkOutput("fetch addr", imemBus.imem_addr, ev.addr);
                        checkOutput("halted at fetch", halted, 0);
                        monExpWrap = ev.wrap;
                        if (ev.gap >= 0 && monLastFetch >= 0)
                            checkOutput("fetch gap", monCyc - monLastFetch, ev.gap);
                    end
                end
                monLastFetch = monCyc;
            end

            if (instr_valid && !monPrevValid) begin
                checkOutput("issue expected", 32'(expQ.size() > 0), 1);
                monInstr = 'x;
                monPc    = 'x;
                if (expQ.size() > 0) begin
                    ev = expQ.pop_front();
                    checkOutput("issue event kind", ev.kind, EV_ISSUE);
                    monInstr = ev.data;
                    monPc    = ev.addr;
                end
                issueSeen++;
            end
            if (instr_valid) begin
                checkOutput("instr", instr, monInstr);
                checkOutput("pc during issue", pc, monPc);
                checkOutput("req during issue", imemBus.imem_req, 0);
            end

            if (halted && !monPrevHalted) begin
                checkOutput("halt expected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    ev = expQ.pop_front();
                    checkOutput("halt event kind", ev.kind, EV_HALT);
                    checkOutput("halted pc", pc, ev.addr);
                end
            end
            if (halted) begin
                checkOutput("req while halted", imemBus.imem_req, 0);
                checkOutput("valid while halted", instr_valid, 0);
            end

            checkOutput("pc_wrap", pc_wrap, monExpWrap);

            monPrevReq    = imemBus.imem_req;
            monPrevValid  = instr_valid;
            monPrevHalted = halted;
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, " imem_req"}, imemBus.imem_req, 0);
        checkOutput({tag, " instr_valid"}, instr_valid, 0);
        checkOutput({tag, " halted"}, halted, 0);
        checkOutput({tag, " pc"}, pc, 8'h00);
        checkOutput({tag, " imem_addr"}, imemBus.imem_addr, 8'h00);
        checkOutput({tag, " pc_wrap"}, pc_wrap, 0);
        checkOutput({tag, " instr"}, instr, 16'h0000);
    endtask

    // Main sequence: directed script first, then free random traffic, then
    // a reset applied while a fetch at 0x33 is outstanding.
    initial begin
        bit found;
        rst_n              = 1'b1;
        start              = 1'b0;
        stall              = 1'b0;
        halt               = 1'b0;
        jump_en            = 1'b0;
        jump_addr          = '0;
        branch_en          = 1'b0;
        branch_off         = '0;
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = '0;
        memBusy            = 1'b0;
        memHold            = 1'b0;
        haveDec            = 1'b0;
        memDelay           = 0;
        instrDelay         = 0;
        stallLeft          = 0;
        stallsThis         = 0;
        monOn              = 1'b0;
        modelPc            = 8'h00;

        #2 rst_n = 1'b0;
        #10;
        checkResetState("reset");
        @(negedge sysclk) rst_n = 1'b1;

        dataQ.push_back(16'h1234);
        for (int i = 0; i < 16; i++) delayQ.push_back(0);
        decQ.push_back(mkDec(0, 0, 0, 0, 8'h00, 8'h00));
        decQ.push_back(mkDec(0, 0, 0, 0, 8'h00, 8'h00));
        decQ.push_back(mkDec(0, 0, 0, 0, 8'h00, 8'h00));
        decQ.push_back(mkDec(0, 0, 1, 0, 8'hFF, 8'h00));
        decQ.push_back(mkDec(0, 0, 0, 0, 8'h00, 8'h00));
        decQ.push_back(mkDec(0, 0, 1, 0, 8'hFF, 8'h00));
        decQ.push_back(mkDec(0, 0, 0, 1, 8'h00, 8'h01));
        decQ.push_back(mkDec(0, 0, 1, 0, 8'h10, 8'h00));
        decQ.push_back(mkDec(0, 0, 1, 1, 8'h40, 8'hFE));
        decQ.push_back(mkDec(0, 0, 1, 0, 8'h10, 8'h00));
        decQ.push_back(mkDec(0, 0, 0, 1, 8'h00, 8'hFE));
        decQ.push_back(mkDec(3, 0, 1, 0, 8'h80, 8'h00));
        decQ.push_back(mkDec(0, 0, 1, 0, 8'h05, 8'h00));
        decQ.push_back(mkDec(0, 1, 0, 0, 8'h00, 8'h00));

        @(negedge sysclk);
        start   = 1'b1;
        modelPc = 8'h00;
        pushFetch(8'h00, 1'b0, -1);
        monOn = 1'b1;

        repeat (120) applyStimulus();
        checkOutput("directed script consumed", decQ.size(), 0);
        repeat (1500) applyStimulus();
        checkOutput("enough issues observed", 32'(issueSeen >= 100), 1);

        memHold = 1'b1;
        decQ.push_back(mkDec(0, 0, 1, 0, 8'h33, 8'h00));
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            if (imemBus.imem_req && pc == 8'h33) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached fetch at 0x33", found, 1);

        @(posedge sysclk);
        #3 rst_n = 1'b0;
        #1;
        checkResetState("async reset");
        expQ.delete();
        decQ.delete();
        memBusy = 1'b0;
        haveDec = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        repeat (2) begin
            @(negedge sysclk);
            imemBus.imem_ack   = 1'b1;
            imemBus.imem_rdata = 16'hBEEF;
        end
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge sysclk);
            checkResetState("late ack");
        end
        imemBus.imem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
